// File: rtl/adc_scan_sequencer_if.sv
// Handshake between the scan sequencer and the 12-bit SPI ADC engine.
// master = sequencer side, slave = SPI engine side.
interface adc_scan_sequencer_if #(
  parameter int CH_W   = 2,
  parameter int DATA_W = 12
);
  logic              spi_start;
  logic [CH_W-1:0]   spi_ch;
  logic              spi_busy;
  logic              spi_done;
  logic [DATA_W-1:0] spi_data;

  modport master (
    output spi_start, spi_ch,
    input  spi_busy, spi_done, spi_data
  );

  modport slave (
    input  spi_start, spi_ch,
    output spi_busy, spi_done, spi_data
  );
endinterface

// File: rtl/adc_scan_sequencer.sv
// Periodic ADC channel scanner: every PERIOD clocks it starts one SPI conversion per
// enabled channel in ascending order and returns channel-tagged results.
//   state     | meaning
//   IDLE      | waiting for a period tick with a non-empty channel mask
//   ISSUE     | waiting for the SPI engine to be free, then pulses spi_start
//   WAIT_DONE | conversion in flight, timeout counter running down
//   NEXT      | pick the next snapshot channel or finish the scan
module adc_scan_sequencer #(
  parameter int NUM_CH  = 4,
  parameter int CH_W    = 2,
  parameter int DATA_W  = 12,
  parameter int PERIOD  = 1000,
  parameter int TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        scan_en,
  input  logic [NUM_CH-1:0]           ch_mask,
  input  logic                        err_clr,
  adc_scan_sequencer_if.master        spi,
  output logic                        result_valid,
  output logic [CH_W-1:0]             result_ch,
  output logic [DATA_W-1:0]           result_data,
  output logic                        scan_done,
  output logic                        busy,
  output logic                        overrun,
  output logic                        timeout_err
);

  localparam int PER_W = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, NEXT} state_t;

  state_t            state_q, state_d;
  logic [PER_W-1:0]  per_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [NUM_CH-1:0] snapshot;
  logic [CH_W-1:0]   ch_q;
  logic              start_q;
  logic              tick;
  logic [CH_W-1:0]   low_ch, next_ch;
  logic              has_next;
  logic              load_snap, set_next, start_d, capture, tmo_hit, done_d, busy_clr;

  assign spi.spi_start = start_q;
  assign spi.spi_ch    = ch_q;
  assign tick          = scan_en && (per_cnt == PER_W'(PERIOD - 1));

  // Descending loops so the last hit is the lowest qualifying channel.
  always_comb begin
    low_ch   = '0;
    next_ch  = '0;
    has_next = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) low_ch = CH_W'(i);
      if (snapshot[i] && (i > int'(ch_q))) begin
        has_next = 1'b1;
        next_ch  = CH_W'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    load_snap = 1'b0;
    set_next  = 1'b0;
    start_d   = 1'b0;
    capture   = 1'b0;
    tmo_hit   = 1'b0;
    done_d    = 1'b0;
    busy_clr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick && (|ch_mask)) begin
          load_snap = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (!scan_en) begin
          busy_clr = 1'b1;
          state_d  = IDLE;
        end else if (!spi.spi_busy) begin
          start_d = 1'b1;
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (spi.spi_done) begin
          capture = 1'b1;
          state_d = NEXT;
        end else if (tmo_cnt == '0) begin
          tmo_hit = 1'b1;
          state_d = NEXT;
        end
      end
      NEXT: begin
        if (has_next && scan_en) begin
          set_next = 1'b1;
          state_d  = ISSUE;
        end else begin
          // A scan cut short by scan_en dropping is not reported as complete.
          done_d   = scan_en;
          busy_clr = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      per_cnt      <= '0;
      tmo_cnt      <= '0;
      snapshot     <= '0;
      ch_q         <= '0;
      start_q      <= 1'b0;
      result_valid <= 1'b0;
      result_ch    <= '0;
      result_data  <= '0;
      scan_done    <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      result_valid <= capture;
      scan_done    <= done_d;

      if (!scan_en || tick) per_cnt <= '0;
      else                  per_cnt <= per_cnt + PER_W'(1);

      if (load_snap) begin
        snapshot <= ch_mask;
        ch_q     <= low_ch;
        busy     <= 1'b1;
      end else if (busy_clr) begin
        busy <= 1'b0;
      end
      if (set_next) ch_q <= next_ch;

      if (start_d)                                    tmo_cnt <= TMO_W'(TIMEOUT);
      else if ((state_q == WAIT_DONE) && (tmo_cnt != '0)) tmo_cnt <= tmo_cnt - TMO_W'(1);

      if (capture) begin
        result_data <= spi.spi_data;
        result_ch   <= ch_q;
      end

      // A set in the same cycle as err_clr takes priority.
      if (tick && busy) overrun <= 1'b1;
      else if (err_clr) overrun <= 1'b0;

      if (tmo_hit)      timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Self-checking bench for adc_scan_sequencer: SPI engine model, start/result scoreboard,
// table-driven single-scan vectors and hand-written multi-cycle sequences.
module tb_adc_scan_sequencer;
  localparam int NUM_CH  = 4;
  localparam int CH_W    = 2;
  localparam int DATA_W  = 12;
  localparam int PERIOD  = 20;
  localparam int TIMEOUT = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              scan_en = 1'b0;
  logic              err_clr = 1'b0;
  logic [NUM_CH-1:0] ch_mask = '0;
  logic              result_valid;
  logic [CH_W-1:0]   result_ch;
  logic [DATA_W-1:0] result_data;
  logic              scan_done, busy, overrun, timeout_err;

  adc_scan_sequencer_if #(.CH_W(CH_W), .DATA_W(DATA_W)) spi_if ();

  adc_scan_sequencer #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .DATA_W(DATA_W), .PERIOD(PERIOD), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .scan_en(scan_en), .ch_mask(ch_mask), .err_clr(err_clr),
    .spi(spi_if), .result_valid(result_valid), .result_ch(result_ch),
    .result_data(result_data), .scan_done(scan_done), .busy(busy),
    .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SPI engine model: done pulses lat clocks after the start pulse, data = ch*0x111;
  // a start on hang_ch is swallowed without any response.
  int                lat = 5;
  int                hang_ch = -1;
  int                m_rem = 0;
  logic              m_busy = 1'b0;
  logic              m_done = 1'b0;
  logic [DATA_W-1:0] m_data = '0;
  assign spi_if.spi_busy = m_busy;
  assign spi_if.spi_done = m_done;
  assign spi_if.spi_data = m_data;

  always @(posedge clk) begin
    m_done <= 1'b0;
    if (spi_if.spi_start) begin
      if (int'(spi_if.spi_ch) != hang_ch) begin
        m_data <= DATA_W'(int'(spi_if.spi_ch) * 'h111);
        if (lat <= 1) m_done <= 1'b1;
        else begin
          m_busy <= 1'b1;
          m_rem  <= lat - 1;
        end
      end
    end else if (m_busy) begin
      if (m_rem == 1) begin
        m_done <= 1'b1;
        m_busy <= 1'b0;
      end else begin
        m_rem <= m_rem - 1;
      end
    end
  end

  typedef struct {
    logic [CH_W-1:0]   ch;
    logic [DATA_W-1:0] data;
  } res_t;

  logic [CH_W-1:0] exp_start[$];
  res_t            exp_res[$];
  logic [CH_W-1:0] e_ch;
  res_t            e_res;
  int              n_start = 0;
  int              n_done = 0;
  int              start_cyc = 0;
  int              tmo_delta = -1;
  logic            tmo_prev = 1'b0;
  bit              busy_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s", name);
  endtask

  always @(negedge clk) begin
    if (spi_if.spi_start) begin
      n_start++;
      start_cyc = cyc;
      if (exp_start.size() == 0) fail_now($sformatf("start_unexpected ch=%0d", spi_if.spi_ch));
      else begin
        e_ch = exp_start.pop_front();
        chk("start_ch", 32'(spi_if.spi_ch), 32'(e_ch));
      end
    end
    if (result_valid) begin
      if (exp_res.size() == 0) fail_now($sformatf("result_unexpected ch=%0d", result_ch));
      else begin
        e_res = exp_res.pop_front();
        chk("result_ch", 32'(result_ch), 32'(e_res.ch));
        chk("result_data", 32'(result_data), 32'(e_res.data));
      end
    end
    if (scan_done) n_done++;
    if (busy) busy_seen = 1'b1;
    if (timeout_err && !tmo_prev) tmo_delta = cyc - start_cyc;
    tmo_prev = timeout_err;
  end

  task automatic push_scan(input logic [NUM_CH-1:0] mask, input int l, input int h);
    res_t r;
    for (int c = 0; c < NUM_CH; c++) begin
      if (mask[c]) begin
        exp_start.push_back(CH_W'(c));
        if (c != h && l <= TIMEOUT) begin
          r.ch   = CH_W'(c);
          r.data = DATA_W'(c * 'h111);
          exp_res.push_back(r);
        end
      end
    end
  endtask

  task automatic run_until_idle(input string name);
    bit saw = 1'b0;
    bit ok  = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (busy) saw = 1'b1;
      else if (saw) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now({name, "_scan_wait_expired"});
  endtask

  task automatic wait_start(input int base, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (n_start > base) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now({name, "_start_wait_expired"});
  endtask

  task automatic clear_errs(input string name);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
    chk({name, "_overrun_clr"}, 32'(overrun), 32'd0);
    chk({name, "_timeout_clr"}, 32'(timeout_err), 32'd0);
    chk({name, "_start_left"}, 32'(exp_start.size()), 32'd0);
    chk({name, "_res_left"}, 32'(exp_res.size()), 32'd0);
    exp_start.delete();
    exp_res.delete();
  endtask

  typedef struct {
    logic [NUM_CH-1:0] mask;
    int                lat;
    int                hang;
    bit                exp_tmo;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "bench watchdog");
  end

  initial begin
    int s0, d0;
    bit found;

    vecs[0] = '{4'b1011,  5, -1, 1'b0};
    vecs[1] = '{4'b0011,  5,  1, 1'b1};
    vecs[2] = '{4'b0001,  1, -1, 1'b0};
    vecs[3] = '{4'b1000, 10, -1, 1'b0};
    vecs[4] = '{4'b0100, 11, -1, 1'b1};
    vecs[5] = '{4'b0110,  2, -1, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_spi_start", 32'(spi_if.spi_start), 32'd0);
    chk("rst_spi_ch", 32'(spi_if.spi_ch), 32'd0);
    chk("rst_result_valid", 32'(result_valid), 32'd0);
    chk("rst_result_ch", 32'(result_ch), 32'd0);
    chk("rst_result_data", 32'(result_data), 32'd0);
    chk("rst_scan_done", 32'(scan_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      ch_mask   = vecs[v].mask;
      lat       = vecs[v].lat;
      hang_ch   = vecs[v].hang;
      push_scan(vecs[v].mask, vecs[v].lat, vecs[v].hang);
      d0        = n_done;
      tmo_delta = -1;
      scan_en   = 1'b1;
      run_until_idle($sformatf("v%0d", v));
      scan_en = 1'b0;
      repeat (2) @(negedge clk);
      chk($sformatf("v%0d_scan_done", v), 32'(n_done - d0), 32'd1);
      chk($sformatf("v%0d_timeout_err", v), 32'(timeout_err), 32'(vecs[v].exp_tmo));
      if (vecs[v].exp_tmo) chk($sformatf("v%0d_tmo_latency", v), 32'(tmo_delta), 32'(TIMEOUT + 1));
      clear_errs($sformatf("v%0d", v));
    end
    hang_ch = -1;

    // Empty mask: ticks must not start anything.
    ch_mask   = 4'b0000;
    s0        = n_start;
    d0        = n_done;
    busy_seen = 1'b0;
    scan_en   = 1'b1;
    repeat (100) @(negedge clk);
    scan_en = 1'b0;
    chk("mask0_starts", 32'(n_start - s0), 32'd0);
    chk("mask0_scan_done", 32'(n_done - d0), 32'd0);
    chk("mask0_busy", 32'(busy_seen), 32'd0);

    // Slow scan overlapping two ticks: overrun, no restart mid-scan.
    ch_mask = 4'b1111;
    lat     = 8;
    push_scan(4'b1111, 8, -1);
    s0      = n_start;
    d0      = n_done;
    scan_en = 1'b1;
    run_until_idle("ovr");
    scan_en = 1'b0;
    @(negedge clk);
    chk("ovr_overrun", 32'(overrun), 32'd1);
    chk("ovr_starts", 32'(n_start - s0), 32'd4);
    chk("ovr_scan_done", 32'(n_done - d0), 32'd1);
    clear_errs("ovr");

    // Mask widened after the first start: snapshot keeps this scan to ch0.
    ch_mask = 4'b0001;
    lat     = 3;
    push_scan(4'b0001, 3, -1);
    push_scan(4'b1111, 3, -1);
    s0      = n_start;
    d0      = n_done;
    scan_en = 1'b1;
    wait_start(s0, "snap");
    ch_mask = 4'b1111;
    found   = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (n_done - d0 >= 2) begin
        found = 1'b1;
        break;
      end
    end
    scan_en = 1'b0;
    if (!found) fail_now("snap_done_wait_expired");
    chk("snap_starts", 32'(n_start - s0), 32'd5);
    clear_errs("snap");

    // Timeout with err_clr held high: the set wins for one cycle, then clears.
    ch_mask = 4'b0001;
    lat     = 11;
    push_scan(4'b0001, 11, -1);
    d0      = n_done;
    err_clr = 1'b1;
    scan_en = 1'b1;
    found   = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (timeout_err) begin
        found = 1'b1;
        break;
      end
    end
    chk("clr_set_wins", 32'(found), 32'd1);
    @(negedge clk);
    chk("clr_next_cycle", 32'(timeout_err), 32'd0);
    repeat (3) @(negedge clk);
    scan_en = 1'b0;
    err_clr = 1'b0;
    chk("clr_scan_done", 32'(n_done - d0), 32'd1);
    clear_errs("clr");

    // Reset during WAIT_DONE: outputs drop at once, late done ignored, rescan from lowest.
    ch_mask = 4'b0110;
    lat     = 8;
    exp_start.push_back(CH_W'(1));
    s0      = n_start;
    scan_en = 1'b1;
    wait_start(s0, "rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs",
        32'({spi_if.spi_start, spi_if.spi_ch, result_valid, result_ch, result_data,
             scan_done, busy, overrun, timeout_err}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    d0    = n_done;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk($sformatf("rst_quiet_%0d", i), 32'({spi_if.spi_start, result_valid, busy, scan_done}), 32'd0);
    end
    push_scan(4'b0110, 8, -1);
    run_until_idle("rst_rescan");
    scan_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rescan_done", 32'(n_done - d0), 32'd1);
    clear_errs("rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
